wb_protocol_monitor: RTL



---
 rtl/wb_mon_pkg.sv | 32 +++
 rtl/wb_mon_rst_chk.sv | 41 ++++
 rtl/wb_protocol_monitor.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wb_mon_pkg.sv
// ---------------------------------------------------------------------------
// wb_mon_pkg
// Shared types and constants for the Wishbone B3 classic-cycle monitor:
//   mon_state_t    - transfer tracking state (IDLE / WAIT)
//   ERR_*          - bit positions inside err_sticky_o
//   NUM_ERR        - number of violation classes
//   first_err_idx  - lowest set bit of a violation vector
// ---------------------------------------------------------------------------
package wb_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mon_state_t;

  localparam int ERR_RST_BUS    = 0;
  localparam int ERR_RST_SHORT  = 1;
  localparam int ERR_STB_NO_CYC = 2;
  localparam int ERR_ACK_NO_STB = 3;
  localparam int ERR_REQ_CHANGE = 4;
  localparam int ERR_TIMEOUT    = 5;
  localparam int NUM_ERR        = 6;

  // Priority encoder: index of the lowest set bit (0 when none is set).
  function automatic logic [2:0] first_err_idx(input logic [NUM_ERR-1:0] v);
    first_err_idx = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (v[i]) first_err_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/wb_mon_rst_chk.sv
// ---------------------------------------------------------------------------
// wb_mon_rst_chk
// Watches the bus reset itself. Its state must survive wb_rst_i, so nothing
// here is cleared by it.
// Ports:
//   wb_clk_i     bus clock
//   wb_rst_i     observed bus reset (active high)
//   wb_cyc_i     observed cycle
//   wb_stb_i     observed strobe
//   rst_bus_o    cyc or stb high while reset is asserted (this cycle)
//   rst_short_o  reset falls this cycle after fewer than MIN_RST_CYC cycles
// ---------------------------------------------------------------------------
module wb_mon_rst_chk #(
  parameter int MIN_RST_CYC = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic wb_cyc_i,
  input  logic wb_stb_i,
  output logic rst_bus_o,
  output logic rst_short_o
);

  // Consecutive high cycles of wb_rst_i seen so far; zero while reset is low,
  // so a non-zero value in a cycle with reset low marks the falling edge.
  logic [7:0] rst_len;

  // NOTE: this register has no reset on purpose: it measures the reset pulse
  // itself and would be wiped by the very event it is timing.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      if (rst_len != 8'hFF) rst_len <= rst_len + 8'd1;
    end else begin
      rst_len <= 8'd0;
    end
  end

  assign rst_bus_o   = wb_rst_i & (wb_cyc_i | wb_stb_i);
  assign rst_short_o = ~wb_rst_i & (rst_len != 8'd0) & (int'(rst_len) < MIN_RST_CYC);

endmodule

// File: rtl/wb_protocol_monitor.sv
// ---------------------------------------------------------------------------
// wb_protocol_monitor
// Passive Wishbone B3 classic-cycle monitor on the SDRAM controller slave
// port. Never drives the bus. Flags violations (sticky + pulse), captures the
// first error and counts completed transfers.
// Optional statistics outputs are enabled with the macro WB_MON_STATS_EN.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset (observed)
//   wb_cyc_i .. wb_ack_o      observed bus signals (all inputs)
//   err_clr_i                 clears sticky bits and first-error capture
//   err_sticky_o[5:0]         sticky violation bits (see wb_mon_pkg ERR_*)
//   err_pulse_o               one-cycle pulse when any bit is newly set
//   first_err_code_o          lowest violated index + 1 of first error, 0 = none
//   first_err_addr_o          wb_addr_i at the first error
//   txn_cnt_o                 completed transfers, wraps
//   busy_o                    a transfer is waiting for ack
//   rd_cnt_o, wr_cnt_o        (WB_MON_STATS_EN) per-direction completions
//   max_lat_o                 (WB_MON_STATS_EN) largest ack latency, saturating
// ---------------------------------------------------------------------------
module wb_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int MIN_RST_CYC = 2,
  parameter int CW          = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic            wb_ack_o,
  input  logic            err_clr_i,
  output logic [5:0]      err_sticky_o,
  output logic            err_pulse_o,
  output logic [2:0]      first_err_code_o,
  output logic [AW-1:0]   first_err_addr_o,
  output logic [CW-1:0]   txn_cnt_o,
  output logic            busy_o
`ifdef WB_MON_STATS_EN
  ,
  output logic [CW-1:0]   rd_cnt_o,
  output logic [CW-1:0]   wr_cnt_o,
  output logic [15:0]     max_lat_o
`endif
);

  // Bits that belong to the reset checker and are kept through wb_rst_i.
  localparam logic [NUM_ERR-1:0] RST_KEEP = 6'b000011;

  mon_state_t          state;
  logic [AW-1:0]       lat_addr;
  logic                lat_we;
  logic [DW/8-1:0]     lat_sel;
  logic [15:0]         wait_cnt;
  logic                drain;      // timed-out request still held; ignore it
  logic                rst_bus, rst_short;
  logic                req, req_changed, to_hit, txn_done, keep_first;
  logic [15:0]         wait_cnt_inc;
  logic [NUM_ERR-1:0]  det;

  wb_mon_rst_chk #(.MIN_RST_CYC(MIN_RST_CYC)) u_rst_chk (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .rst_bus_o   (rst_bus),
    .rst_short_o (rst_short)
  );

  assign req          = wb_cyc_i & wb_stb_i;
  assign req_changed  = (wb_addr_i != lat_addr) | (wb_we_i != lat_we) | (wb_sel_i != lat_sel);
  assign wait_cnt_inc = wait_cnt + 16'd1;
  assign to_hit       = (state == WAIT) & req & ~wb_ack_o & (int'(wait_cnt_inc) == TIMEOUT_CYC);
  assign txn_done     = ~wb_rst_i & req & wb_ack_o & ((state == WAIT) | ~drain);
  assign keep_first   = (first_err_code_o == 3'(ERR_RST_BUS + 1)) ||
                        (first_err_code_o == 3'(ERR_RST_SHORT + 1));
  assign busy_o       = (state == WAIT);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    det                = '0;
    det[ERR_RST_BUS]   = rst_bus;
    det[ERR_RST_SHORT] = rst_short;
    if (!wb_rst_i) begin
      det[ERR_STB_NO_CYC] = wb_stb_i & ~wb_cyc_i;
      det[ERR_ACK_NO_STB] = wb_ack_o & ~req;
      det[ERR_REQ_CHANGE] = (state == WAIT) & (~req | req_changed);
      det[ERR_TIMEOUT]    = to_hit;
    end
  end

  // Transfer tracking FSM and transaction counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      wait_cnt  <= '0;
      drain     <= 1'b0;
      txn_cnt_o <= '0;
    end else begin
      if (txn_done) txn_cnt_o <= txn_cnt_o + CW'(1);
      case (state)
        IDLE: begin
          if (drain) begin
            if (!req) drain <= 1'b0;
          end else if (req && !wb_ack_o) begin
            state    <= WAIT;
            lat_addr <= wb_addr_i;
            lat_we   <= wb_we_i;
            lat_sel  <= wb_sel_i;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (!req || wb_ack_o) begin
            state <= IDLE;
          end else if (to_hit) begin
            state <= IDLE;
            drain <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_inc;
            // Re-latch so a single change is flagged once, not every cycle.
            lat_addr <= wb_addr_i;
            lat_we   <= wb_we_i;
            lat_sel  <= wb_sel_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky bits and pulse; clear wins over a same-cycle violation.
  always_ff @(posedge wb_clk_i) begin
    if (err_clr_i) begin
      err_sticky_o <= '0;
      err_pulse_o  <= 1'b0;
    end else begin
      err_sticky_o <= (wb_rst_i ? (err_sticky_o & RST_KEEP) : err_sticky_o) | det;
      err_pulse_o  <= |(det & ~err_sticky_o);
    end
  end

  // First-error capture. Reset drops a capture of a bus-side error but keeps
  // one that refers to the reset-persistent bits.
  always_ff @(posedge wb_clk_i) begin
    if (err_clr_i) begin
      first_err_code_o <= '0;
      first_err_addr_o <= '0;
    end else if (wb_rst_i) begin
      if (!keep_first) begin
        if (det[ERR_RST_BUS]) begin
          first_err_code_o <= 3'(ERR_RST_BUS + 1);
          first_err_addr_o <= wb_addr_i;
        end else begin
          first_err_code_o <= '0;
          first_err_addr_o <= '0;
        end
      end
    end else if (first_err_code_o == 3'd0 && |det) begin
      first_err_code_o <= first_err_idx(det) + 3'd1;
      first_err_addr_o <= wb_addr_i;
    end
  end

`ifdef WB_MON_STATS_EN
  logic [15:0] cur_lat;

  // Single-cycle acks in IDLE have latency 0.
  assign cur_lat = (state == IDLE) ? 16'd0 :
                   (wait_cnt == 16'hFFFF) ? 16'hFFFF : wait_cnt_inc;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      max_lat_o <= '0;
    end else if (txn_done) begin
      if (wb_we_i) wr_cnt_o <= wr_cnt_o + CW'(1);
      else         rd_cnt_o <= rd_cnt_o + CW'(1);
      if (cur_lat > max_lat_o) max_lat_o <= cur_lat;
    end
  end
`endif

endmodule
